// File: rtl/mimo_pkg.sv
// Shared fixed-point and word-format constants for the MIMO input packer and detector.
package mimo_pkg;

  localparam int INT_W    = 6;
  localparam int FRAC_W   = 10;
  localparam int SAMPLE_W = INT_W + FRAC_W;
  localparam int LANES    = 8;
  localparam int WORD_W   = SAMPLE_W * LANES;
  localparam int OUT_W    = 12;

endpackage

// File: rtl/mimo_pack_fifo.sv
// Small word FIFO between the packer and the detector: registered pointers,
// occupancy counter and full/empty flags; storage cleared by reset.
module mimo_pack_fifo
  import mimo_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ENTRY_W    = WORD_W + 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] pop_data,
  output logic               full,
  output logic               empty
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mimo_input_packer.sv
// Packs a stream of fixed-point samples into LANES-wide words for the MIMO detector.
// Optional sticky flag-consistency check enabled by defining MIMO_PACK_FLAGCHK_EN.
module mimo_input_packer #(
  parameter int SAMPLE_W   = mimo_pkg::SAMPLE_W,
  parameter int LANES      = mimo_pkg::LANES,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [SAMPLE_W-1:0]       s_data,
  input  logic                      s_flag,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [SAMPLE_W*LANES-1:0] m_data,
  output logic                      m_flag,
  output logic                      err_flag
);

  localparam int WORD_W = SAMPLE_W * LANES;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  logic [LW-1:0]     lane_q, lane_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              flag_q, flag_d;
  logic              push_flag;
  logic              accept, push, pop;
  logic              fifo_full, fifo_empty;
  logic [WORD_W:0]   head;

  // Ready depends only on local state and reset, never on m_ready.
  assign s_ready = !Reset && !((lane_q == LAST_LANE) && fifo_full);
  assign accept  = s_valid && s_ready;
  assign push    = accept && (lane_q == LAST_LANE);
  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign m_data  = head[WORD_W-1:0];
  assign m_flag  = head[WORD_W];

  always_comb begin
    lane_d    = lane_q;
    word_d    = word_q;
    flag_d    = flag_q;
    push_flag = (lane_q == '0) ? s_flag : flag_q;
    if (accept) begin
      word_d[SAMPLE_W*lane_q +: SAMPLE_W] = s_data;
      if (lane_q == '0) flag_d = s_flag;
      lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lane_q <= '0;
      word_q <= '0;
      flag_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      flag_q <= flag_d;
    end
  end

  mimo_pack_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ENTRY_W    (WORD_W + 1)
  ) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (push),
    .push_data ({push_flag, word_d}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef MIMO_PACK_FLAGCHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept && (lane_q != '0) && (s_flag != flag_q)) err_d = 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_flag = err_q;
`else
  assign err_flag = 1'b0;
`endif

endmodule

// File: doc/mimo_input_packer.md
MIMO_INPUT_PACKER -- requirements
Module: mimo_input_packer

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, meaning the width of one Q6.10 fixed-point sample (INT_W 6 + FRAC_W 10).
REQ-002 SHALL have parameter LANES, default 8, meaning samples per packed word (4 complex values, 2 parts each).
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of packed words buffered toward the detector.
REQ-004 SHALL have port Clk  input  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port s_valid  input  1  upstream sample valid.
REQ-007 SHALL have port s_ready  output  1  packer accepts a sample this cycle.
REQ-008 SHALL have port s_data  input  SAMPLE_W  one fixed-point sample.
REQ-009 SHALL have port s_flag  input  1  flagChannelorData for the sample (1 = channel, 0 = data).
REQ-010 SHALL have port m_valid  output  1  drives detector i_in_valid.
REQ-011 SHALL have port m_ready  input  1  from detector o_in_ready.
REQ-012 SHALL have port m_data  output  SAMPLE_W*LANES  drives detector InData.
REQ-013 SHALL have port m_flag  output  1  drives detector flagChannelorData.
REQ-014 SHALL have port err_flag  output  1  sticky flag-mismatch error.

Function
REQ-015 A sample SHALL be accepted on a rising edge where s_valid and s_ready are both 1.
REQ-016 Accepted sample k (k = 0..LANES-1 within a word) SHALL be placed at m_data bits [SAMPLE_W*k+SAMPLE_W-1 : SAMPLE_W*k].
REQ-017 A 3-bit lane counter SHALL advance on each accept and wrap from LANES-1 to 0.
REQ-018 The word flag SHALL be latched from s_flag on the lane-0 accept and SHALL be ignored on lanes 1..LANES-1.
REQ-019 On the lane LANES-1 accept, the completed word and its flag SHALL be pushed into the FIFO on the same edge.
REQ-020 s_ready SHALL equal NOT(lane counter == LANES-1 AND FIFO full).
REQ-021 s_ready SHALL have no combinational dependence on m_ready.
REQ-022 m_valid SHALL equal FIFO not empty.
REQ-023 m_data and m_flag SHALL present the FIFO head entry.
REQ-024 A pop SHALL occur on a rising edge where m_valid and m_ready are both 1.
REQ-025 Latency: if the FIFO is empty, m_valid SHALL rise in the cycle after the lane-7 accept edge.
REQ-026 A push and a pop on the same edge SHALL leave occupancy unchanged, with the new word queued behind the remaining one.
REQ-027 m_data and m_flag SHALL hold stable while m_valid=1 and m_ready=0.
REQ-028 Words SHALL be emitted in acceptance order with no loss or duplication.

Reset
REQ-029 Asserting Reset SHALL immediately clear the lane counter, the FIFO (m_valid=0, m_data=0, m_flag=0) and err_flag, and SHALL discard any partial word.
REQ-030 With Reset high, s_ready SHALL be 0; it SHALL become 1 on the first cycle after Reset falls.

Configuration
REQ-031 With MIMO_PACK_FLAGCHK_EN defined, err_flag SHALL be set when an accepted lane 1..LANES-1 sample carries s_flag differing from the latched word flag.
REQ-032 With MIMO_PACK_FLAGCHK_EN defined, err_flag SHALL remain set until Reset.
REQ-033 Without MIMO_PACK_FLAGCHK_EN, err_flag SHALL be tied 0, no compare logic SHALL exist, and datapath behaviour SHALL be identical to the enabled build.

Structure
REQ-034 Package mimo_pkg SHALL hold INT_W=6, FRAC_W=10, SAMPLE_W=16, LANES=8, WORD_W=128 and OUT_W=12, shared with MIMO_detector.
REQ-035 The buffer SHALL be a sub-module mimo_pack_fifo: FIFO_DEPTH entries of WORD_W+1 bits, registered pointers, full/empty flags.

Verification
REQ-036 The bench SHALL cover: 8 samples 0x0001..0x0008, s_flag=1, m_ready=1 -> one word 0x0008_0007_..._0001 with m_flag=1, m_valid high 1 cycle after the 8th accept.
REQ-037 The bench SHALL cover: m_ready=0 while streaming 24 samples -> two words buffered, s_ready=0 at lane 7 of word 3; after m_ready=1 all three words emerge in order.
REQ-038 The bench SHALL cover: FIFO holding 1 word with m_ready=1 on the cycle word 2 completes -> simultaneous push/pop, occupancy stays 1, m_data = word 2 next cycle.
REQ-039 The bench SHALL cover: Reset pulsed after 5 samples -> partial word discarded; the next 8 samples form a clean word with lane 0 = first post-reset sample.
REQ-040 The bench SHALL cover: s_flag=1 on lane 0 and 0 on lane 3 -> m_flag=1; err_flag=1 with MIMO_PACK_FLAGCHK_EN, 0 without it.
REQ-041 The bench SHALL cover: random s_valid/m_ready gaps over 1000 words against a scoreboard -> zero mismatches, including words with s_data=0x8000 and 0x7FFF passed unmodified.
